// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - flush walker state type and walk-order helpers for cache_line_state
package cache_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} flush_state_t;

    function automatic logic walk_is_last(input int s, input int w, input int num_sets, input int assoc);
        return (s == num_sets - 1) && (w == assoc - 1);
    endfunction

    // Way increments fastest; the set only steps when the way wraps.
    function automatic int walk_next_way(input int w, input int assoc);
        return (w + 1 == assoc) ? 0 : w + 1;
    endfunction

    function automatic int walk_next_set(input int s, input int w, input int assoc);
        return (w + 1 == assoc) ? s + 1 : s;
    endfunction

endpackage

// File: rtl/cache_flush_walker.sv
// rtl/cache_flush_walker.sv - flush FSM: walks every line, writes back valid+dirty ones
// Honours CACHE_LINE_STATE_DIRTY_COUNT_EN (skip the scan when nothing is dirty).
module cache_flush_walker
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 4,
    parameter int ASSOC    = 2,
    parameter int SET_W    = 2,
    parameter int WAY_W    = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_req,
    input  logic             flush_inval,
`ifdef CACHE_LINE_STATE_DIRTY_COUNT_EN
    input  logic             no_dirty,
`endif
    input  logic             line_valid,
    input  logic             line_dirty,
    input  logic             wb_ready,
    output logic             flush_busy,
    output logic             flush_done,
    output logic             wb_valid,
    output logic [SET_W-1:0] wb_set,
    output logic [WAY_W-1:0] wb_way,
    output logic             clr_valid,
    output logic             clr_dirty
);

    flush_state_t     state;
    logic             inval_q;
    logic             last_line;
    logic [SET_W-1:0] next_set;
    logic [WAY_W-1:0] next_way;

    assign last_line = walk_is_last(32'(wb_set), 32'(wb_way), NUM_SETS, ASSOC);
    assign next_set  = SET_W'(walk_next_set(32'(wb_set), 32'(wb_way), ASSOC));
    assign next_way  = WAY_W'(walk_next_way(32'(wb_way), ASSOC));

    // Clear requests land in the array on the same edge the FSM moves on.
    assign clr_dirty = (state == WB) && wb_ready;
    assign clr_valid = inval_q && (((state == SCAN) && !(line_valid && line_dirty)) || clr_dirty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            inval_q    <= 1'b0;
            wb_set     <= '0;
            wb_way     <= '0;
            flush_busy <= 1'b0;
            flush_done <= 1'b0;
            wb_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        inval_q    <= flush_inval;
                        wb_set     <= '0;
                        wb_way     <= '0;
                        flush_busy <= 1'b1;
`ifdef CACHE_LINE_STATE_DIRTY_COUNT_EN
                        if (no_dirty && !flush_inval) begin
                            state      <= DONE;
                            flush_done <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
`else
                        state <= SCAN;
`endif
                    end
                end
                SCAN: begin
                    if (line_valid && line_dirty) begin
                        state    <= WB;
                        wb_valid <= 1'b1;
                    end else if (last_line) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end else begin
                        wb_set <= next_set;
                        wb_way <= next_way;
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        if (last_line) begin
                            state      <= DONE;
                            flush_done <= 1'b1;
                        end else begin
                            state  <= SCAN;
                            wb_set <= next_set;
                            wb_way <= next_way;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    flush_done <= 1'b0;
                    flush_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cache_line_state.sv
// rtl/cache_line_state.sv - per-line valid/dirty array with flush walker
// CACHE_LINE_STATE_DIRTY_COUNT_EN adds the dirty_count output and the empty-flush shortcut.
module cache_line_state
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 4,
    parameter int ASSOC    = 2,
    localparam int SET_W   = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int WAY_W   = (ASSOC > 1) ? $clog2(ASSOC) : 1,
    localparam int CNT_W   = $clog2(NUM_SETS * ASSOC + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SET_W-1:0] set,
    input  logic [WAY_W-1:0] way,
    input  logic             set_valid,
    input  logic             clear_valid,
    input  logic             set_dirty,
    input  logic             clear_dirty,
    output logic             valid,
    output logic             dirty,
    input  logic             flush_req,
    input  logic             flush_inval,
    output logic             flush_busy,
    output logic             flush_done,
    output logic             wb_valid,
    output logic [SET_W-1:0] wb_set,
    output logic [WAY_W-1:0] wb_way,
    input  logic             wb_ready
`ifdef CACHE_LINE_STATE_DIRTY_COUNT_EN
    ,
    output logic [CNT_W-1:0] dirty_count
`endif
);

    logic [ASSOC-1:0] valid_arr [NUM_SETS];
    logic [ASSOC-1:0] dirty_arr [NUM_SETS];
    logic [SET_W-1:0] wr_set;
    logic [WAY_W-1:0] wr_way;
    logic             clr_valid, clr_dirty;
    logic             old_v, old_d, new_v, new_d;

    assign valid = valid_arr[set][way];
    assign dirty = dirty_arr[set][way];

    cache_flush_walker #(
        .NUM_SETS (NUM_SETS),
        .ASSOC    (ASSOC),
        .SET_W    (SET_W),
        .WAY_W    (WAY_W)
    ) u_walker (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_req   (flush_req),
        .flush_inval (flush_inval),
`ifdef CACHE_LINE_STATE_DIRTY_COUNT_EN
        .no_dirty    (dirty_count == '0),
`endif
        .line_valid  (valid_arr[wb_set][wb_way]),
        .line_dirty  (dirty_arr[wb_set][wb_way]),
        .wb_ready    (wb_ready),
        .flush_busy  (flush_busy),
        .flush_done  (flush_done),
        .wb_valid    (wb_valid),
        .wb_set      (wb_set),
        .wb_way      (wb_way),
        .clr_valid   (clr_valid),
        .clr_dirty   (clr_dirty)
    );

    // One line is written per cycle: the walker owns the array while busy, the access port otherwise.
    always_comb begin
        wr_set = flush_busy ? wb_set : set;
        wr_way = flush_busy ? wb_way : way;
        old_v  = valid_arr[wr_set][wr_way];
        old_d  = dirty_arr[wr_set][wr_way];
        new_v  = old_v;
        new_d  = old_d;
        if (flush_busy) begin
            if (clr_valid) new_v = 1'b0;
            if (clr_dirty) new_d = 1'b0;
        end else begin
            if (clear_valid)    new_v = 1'b0;
            else if (set_valid) new_v = 1'b1;
            if (clear_dirty)    new_d = 1'b0;
            else if (set_dirty) new_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
            end
        end else begin
            valid_arr[wr_set][wr_way] <= new_v;
            dirty_arr[wr_set][wr_way] <= new_d;
        end
    end

`ifdef CACHE_LINE_STATE_DIRTY_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dirty_count <= '0;
        end else if ((new_v && new_d) && !(old_v && old_d)) begin
            dirty_count <= dirty_count + 1'b1;
        end else if (!(new_v && new_d) && (old_v && old_d)) begin
            dirty_count <= dirty_count - 1'b1;
        end
    end
`endif

endmodule
